bus_display_scanner: RTL

// - Downstream consumer of the single-cycle computer's observable state (PCout, BusA, BusB, BusD).
// - Captures the four bytes into shadow registers on a sample strobe.
// - Time-multiplexes them as 8 hex digits onto one shared 7-segment driver plus 8 digit enables.
// - Replaces eight static nibble decoders with a scanned display; supports snapshot freeze for stepping.

---
 rtl/bus_display_scanner.sv | 97 +++++++++
 1 files changed

// File: rtl/bus_display_scanner.sv
// Scanned 8-digit hex display of PCout/BusA/BusB/BusD shadow registers with snapshot freeze.
// Optional SEG_DIM_EN adds a Bright[2:0] input for PWM dimming of the selected digit.
module bus_display_scanner #(
  parameter int DIGIT_TICKS = 50000,
  parameter int PS_W        = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] pcout_i,
  input  logic [7:0] bus_a_i,
  input  logic [7:0] bus_b_i,
  input  logic [7:0] bus_d_i,
  input  logic       sample_i,
  input  logic       freeze_i,
`ifdef SEG_DIM_EN
  input  logic [2:0] bright_i,
`endif
  output logic [6:0] seg_o,
  output logic [7:0] digit_en_o
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIGIT_TICKS - 1);

  logic [31:0]     shadow_q, shadow_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [7:0]      den_q, den_d;
  logic [3:0]      nib;
  logic            wrap;
  logic            dig_on;

  // Active-low gfedcba patterns.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

`ifdef SEG_DIM_EN
  logic [2:0] pwm_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pwm_q <= 3'd0;
    else       pwm_q <= pwm_q + 3'd1;
  assign dig_on = (pwm_q <= bright_i);
`else
  assign dig_on = 1'b1;
`endif

  assign wrap = (ps_q == PS_LAST);
  assign nib  = shadow_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    shadow_d = shadow_q;
    if (sample_i && !freeze_i) shadow_d = {bus_d_i, bus_b_i, bus_a_i, pcout_i};
    ps_d  = wrap ? '0 : ps_q + 1'b1;
    idx_d = wrap ? idx_q + 3'd1 : idx_q;
    // Outputs reflect the current index/shadow, so any change lands one cycle later.
    seg_d = hex7(nib);
    den_d = dig_on ? ~(8'b1 << idx_q) : 8'hFF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      ps_q     <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      den_q    <= 8'hFF;
    end else begin
      shadow_q <= shadow_d;
      ps_q     <= ps_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      den_q    <= den_d;
    end
  end

  assign seg_o      = seg_q;
  assign digit_en_o = den_q;

endmodule
